// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display constants and types for the VGA plot path
// Purpose: VGA coordinate/colour widths, layer channel indices, default slot
//          lengths, the slot scheduler state type and a channel-index width helper.
// Ports: none (package).
package display_pkg;

   localparam int VGA_X_W = 8;
   localparam int VGA_Y_W = 8;
   localparam int VGA_C_W = 3;

   localparam int CH_MAP  = 0;
   localparam int CH_CHAR = 1;

   localparam int DEF_SLOT_MAP  = 11050;
   localparam int DEF_SLOT_CHAR = 50;

   typedef enum logic {
      ST_LOAD  = 1'b0,
      ST_SERVE = 1'b1
   } slot_state_t;

   // A single-channel build still needs a 1-bit channel index.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/slot_scheduler.sv
// rtl/slot_scheduler.sv - time-slice owner sequencer for the VGA plot arbiter
// Purpose: walks the channels round-robin, giving each slot_len[i] serve cycles
//          preceded by one LOAD bubble; optional early slot end on idle request.
// Ports:
//   clock_50, reset      clock, synchronous active-high reset
//   en                   low freezes state, cur and cnt
//   slot_len             NUM_CH packed slot lengths, sampled in LOAD only
//   ch_req               per-channel pixel valid (used for idle skipping)
//   serving              high while the current owner may be granted
//   cur                  channel currently owning the slot
//   frame_start          one-cycle pulse when ownership wraps to channel 0
module slot_scheduler
   import display_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int SLOT_W    = 15,
   parameter int SKIP_IDLE = 0,
   localparam int CH_W     = ch_idx_w(NUM_CH)
) (
   input  logic                     clock_50,
   input  logic                     reset,
   input  logic                     en,
   input  logic [NUM_CH*SLOT_W-1:0] slot_len,
   input  logic [NUM_CH-1:0]        ch_req,
   output logic                     serving,
   output logic [CH_W-1:0]          cur,
   output logic                     frame_start
);

   slot_state_t        state, state_nxt;
   logic [SLOT_W-1:0]  cnt, cnt_nxt, len_cur;
   logic [CH_W-1:0]    cur_nxt;
   logic               advance;
   logic               at_last;

   assign len_cur = slot_len[cur*SLOT_W +: SLOT_W];
   assign at_last = (cur == CH_W'(NUM_CH - 1));
   assign serving = (state == ST_SERVE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      advance   = 1'b0;
      if (en) begin
         case (state)
            ST_LOAD: begin
               cnt_nxt = len_cur;
               // Zero-length channels still cost their LOAD cycle, then hand on.
               if (len_cur == '0) advance = 1'b1;
               else               state_nxt = ST_SERVE;
            end
            ST_SERVE: begin
               if ((SKIP_IDLE != 0) && !ch_req[cur]) begin
                  advance   = 1'b1;
                  state_nxt = ST_LOAD;
               end else begin
                  cnt_nxt = cnt - 1'b1;
                  if (cnt == SLOT_W'(1)) begin
                     advance   = 1'b1;
                     state_nxt = ST_LOAD;
                  end
               end
            end
         endcase
      end
      cur_nxt = advance ? (at_last ? '0 : cur + 1'b1) : cur;
   end

   always_ff @(posedge clock_50) begin
      if (reset) begin
         state       <= ST_LOAD;
         cur         <= '0;
         cnt         <= '0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nxt;
         cur         <= cur_nxt;
         cnt         <= cnt_nxt;
         frame_start <= advance & at_last;
      end
   end

endmodule

// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - time-sliced merge of per-layer pixel streams onto one VGA plot port
// Purpose: grants the slot owner's pixel when it is valid and drives a registered
//          plot strobe with that pixel's coordinates and colour one cycle later.
// Ports:
//   clock_50, reset             clock, synchronous active-high reset
//   en                          global enable; low freezes arbitration
//   slot_len                    per-channel slot length, channel i at [i*SLOT_W +: SLOT_W]
//   ch_req/ch_x/ch_y/ch_color   per-channel pixel valid and fields, packed the same way
//   ch_grant                    combinational accept; pixel moves on ch_req & ch_grant
//   vga_plot/x/y/color          registered VGA write
//   active_ch                   slot owner
//   frame_start                 pulse when ownership wraps to channel 0
module vga_plot_arbiter
   import display_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int X_W       = VGA_X_W,
   parameter int Y_W       = VGA_Y_W,
   parameter int C_W       = VGA_C_W,
   parameter int SLOT_W    = 15,
   parameter int SKIP_IDLE = 0,
   localparam int CH_W     = ch_idx_w(NUM_CH)
) (
   input  logic                     clock_50,
   input  logic                     reset,
   input  logic                     en,
   input  logic [NUM_CH*SLOT_W-1:0] slot_len,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH*X_W-1:0]    ch_x,
   input  logic [NUM_CH*Y_W-1:0]    ch_y,
   input  logic [NUM_CH*C_W-1:0]    ch_color,
   output logic [NUM_CH-1:0]        ch_grant,
   output logic                     vga_plot,
   output logic [X_W-1:0]           vga_x,
   output logic [Y_W-1:0]           vga_y,
   output logic [C_W-1:0]           vga_color,
   output logic [CH_W-1:0]          active_ch,
   output logic                     frame_start
);

   logic serving;
   logic transfer;

   slot_scheduler #(
      .NUM_CH    (NUM_CH),
      .SLOT_W    (SLOT_W),
      .SKIP_IDLE (SKIP_IDLE)
   ) u_sched (
      .clock_50    (clock_50),
      .reset       (reset),
      .en          (en),
      .slot_len    (slot_len),
      .ch_req      (ch_req),
      .serving     (serving),
      .cur         (active_ch),
      .frame_start (frame_start)
   );

   always_comb begin
      ch_grant = '0;
      if (serving && en && ch_req[active_ch]) ch_grant[active_ch] = 1'b1;
   end

   assign transfer = |ch_grant;

   // Coordinates and colour hold between plots so the adapter sees stable data.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         vga_plot  <= 1'b0;
         vga_x     <= '0;
         vga_y     <= '0;
         vga_color <= '0;
      end else begin
         vga_plot <= transfer;
         if (transfer) begin
            vga_x     <= ch_x[active_ch*X_W +: X_W];
            vga_y     <= ch_y[active_ch*Y_W +: Y_W];
            vga_color <= ch_color[active_ch*C_W +: C_W];
         end
      end
   end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - self-checking bench for vga_plot_arbiter
module tb_vga_plot_arbiter;

   logic clock_50 = 1'b0;
   logic reset;
   always #10 clock_50 = ~clock_50;

   int n_tests = 0;
   int n_fail  = 0;

   // A: 2 channels fixed TDM
   logic        a_en;
   logic [29:0] a_slot_len;
   logic [1:0]  a_req, a_grant;
   logic [15:0] a_x, a_y;
   logic [5:0]  a_c;
   logic        a_plot, a_act, a_frame;
   logic [7:0]  a_vx, a_vy;
   logic [2:0]  a_vc;

   // B: 2 channels, idle skipping
   logic        b_en;
   logic [29:0] b_slot_len;
   logic [1:0]  b_req, b_grant;
   logic [15:0] b_x, b_y;
   logic [5:0]  b_c;
   logic        b_plot, b_act, b_frame;
   logic [7:0]  b_vx, b_vy;
   logic [2:0]  b_vc;

   // C: 3 channels fixed TDM
   logic        c_en;
   logic [44:0] c_slot_len;
   logic [2:0]  c_req, c_grant;
   logic [23:0] c_x, c_y;
   logic [8:0]  c_c;
   logic        c_plot, c_frame;
   logic [1:0]  c_act;
   logic [7:0]  c_vx, c_vy;
   logic [2:0]  c_vc;

   vga_plot_arbiter #(.NUM_CH(2), .X_W(8), .Y_W(8), .C_W(3), .SLOT_W(15), .SKIP_IDLE(0)) dut_a (
      .clock_50(clock_50), .reset(reset), .en(a_en), .slot_len(a_slot_len), .ch_req(a_req),
      .ch_x(a_x), .ch_y(a_y), .ch_color(a_c), .ch_grant(a_grant), .vga_plot(a_plot),
      .vga_x(a_vx), .vga_y(a_vy), .vga_color(a_vc), .active_ch(a_act), .frame_start(a_frame));

   vga_plot_arbiter #(.NUM_CH(2), .X_W(8), .Y_W(8), .C_W(3), .SLOT_W(15), .SKIP_IDLE(1)) dut_b (
      .clock_50(clock_50), .reset(reset), .en(b_en), .slot_len(b_slot_len), .ch_req(b_req),
      .ch_x(b_x), .ch_y(b_y), .ch_color(b_c), .ch_grant(b_grant), .vga_plot(b_plot),
      .vga_x(b_vx), .vga_y(b_vy), .vga_color(b_vc), .active_ch(b_act), .frame_start(b_frame));

   vga_plot_arbiter #(.NUM_CH(3), .X_W(8), .Y_W(8), .C_W(3), .SLOT_W(15), .SKIP_IDLE(0)) dut_c (
      .clock_50(clock_50), .reset(reset), .en(c_en), .slot_len(c_slot_len), .ch_req(c_req),
      .ch_x(c_x), .ch_y(c_y), .ch_color(c_c), .ch_grant(c_grant), .vga_plot(c_plot),
      .vga_x(c_vx), .vga_y(c_vy), .vga_color(c_vc), .active_ch(c_act), .frame_start(c_frame));

   // Leaves the bench on a negedge with reset just released: that cycle is cycle 0.
   task automatic do_reset();
      reset = 1'b1;
      a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
      a_req = '0; b_req = '0; c_req = '0;
      repeat (2) @(negedge clock_50);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      a_en = 1'b1; b_en = 1'b1; c_en = 1'b1;
      a_req = '1; b_req = '1; c_req = '1;
      repeat (2) @(negedge clock_50);
      n_tests++; if ({a_plot, a_vx, a_vy, a_vc, a_grant, a_act, a_frame} !== '0) begin
         n_fail++; $display("FAIL reset_a got %h want 0", {a_plot, a_vx, a_vy, a_vc, a_grant, a_act, a_frame}); end
      n_tests++; if ({b_plot, b_vx, b_vy, b_vc, b_grant, b_act, b_frame} !== '0) begin
         n_fail++; $display("FAIL reset_b got %h want 0", {b_plot, b_vx, b_vy, b_vc, b_grant, b_act, b_frame}); end
      n_tests++; if ({c_plot, c_vx, c_vy, c_vc, c_grant, c_act, c_frame} !== '0) begin
         n_fail++; $display("FAIL reset_c got %h want 0", {c_plot, c_vx, c_vy, c_vc, c_grant, c_act, c_frame}); end
   endtask

   // Reference: the round is laid out as a list of cycles, each a bubble or a
   // serve cycle of some owner; en=1 consumes one list entry per cycle.
   task automatic test_tdm(input int len0, input int len1, input int en_pct,
                           input bit rand_req, input int ncyc);
      int         own[$];
      bit         bub[$];
      int         p, o;
      bit         prev_x, prev_en, ef;
      logic [1:0] eg;
      logic [7:0] ex, ey;
      logic [2:0] ec;
      a_slot_len = {15'(len1), 15'(len0)};
      while (own.size() < ncyc + 4) begin
         for (int ch = 0; ch < 2; ch++) begin
            own.push_back(ch); bub.push_back(1'b1);
            for (int i = 0; i < ((ch == 0) ? len0 : len1); i++) begin
               own.push_back(ch); bub.push_back(1'b0);
            end
         end
      end
      do_reset();
      p = 0; prev_x = 0; prev_en = 0; ex = '0; ey = '0; ec = '0;
      for (int k = 0; k < ncyc; k++) begin
         a_en  = ($urandom_range(0, 99) >= en_pct);
         a_req = rand_req ? 2'($urandom) : 2'b11;
         a_x   = 16'($urandom);
         a_y   = 16'($urandom);
         a_c   = 6'($urandom);
         #1;
         o  = own[p];
         eg = (a_en && !bub[p] && a_req[o]) ? 2'(1 << o) : 2'b00;
         ef = prev_en && bub[p] && (o == 0) && (p > 0);
         n_tests++; if (a_grant !== eg) begin n_fail++; $display("FAIL tdm_grant k=%0d got %b want %b", k, a_grant, eg); end
         n_tests++; if (a_act !== 1'(o)) begin n_fail++; $display("FAIL tdm_active k=%0d got %0d want %0d", k, a_act, o); end
         n_tests++; if (a_frame !== ef) begin n_fail++; $display("FAIL tdm_frame k=%0d got %b want %b", k, a_frame, ef); end
         n_tests++; if (a_plot !== prev_x) begin n_fail++; $display("FAIL tdm_plot k=%0d got %b want %b", k, a_plot, prev_x); end
         n_tests++; if ({a_vx, a_vy, a_vc} !== {ex, ey, ec}) begin
            n_fail++; $display("FAIL tdm_xyc k=%0d got %h want %h", k, {a_vx, a_vy, a_vc}, {ex, ey, ec}); end
         if (eg != 2'b00) begin
            ex = a_x[o*8 +: 8]; ey = a_y[o*8 +: 8]; ec = a_c[o*3 +: 3];
         end
         prev_x  = (eg != 2'b00);
         prev_en = a_en;
         if (a_en) p++;
         @(negedge clock_50);
      end
      a_en = 1'b0;
   endtask

   // Same stimulus into fixed TDM (A) and idle-skipping (B): ch0 drops req at cycle 3.
   task automatic test_skip_idle();
      int exp_a[10] = '{0, 1, 1, 0, 0, 0, 2, 2, 2, 2};
      int exp_b[10] = '{0, 1, 1, 0, 0, 2, 2, 2, 2, 0};
      a_slot_len = {15'd4, 15'd4};
      b_slot_len = {15'd4, 15'd4};
      do_reset();
      for (int k = 0; k < 10; k++) begin
         a_en = 1'b1; b_en = 1'b1;
         a_req = (k >= 3) ? 2'b10 : 2'b11;
         b_req = a_req;
         #1;
         n_tests++; if (a_grant !== 2'(exp_a[k])) begin n_fail++; $display("FAIL noskip_grant k=%0d got %b want %b", k, a_grant, 2'(exp_a[k])); end
         n_tests++; if (b_grant !== 2'(exp_b[k])) begin n_fail++; $display("FAIL skip_grant k=%0d got %b want %b", k, b_grant, 2'(exp_b[k])); end
         n_tests++; if (b_frame !== (k == 9)) begin n_fail++; $display("FAIL skip_frame k=%0d got %b want %b", k, b_frame, (k == 9)); end
         n_tests++; if (a_frame !== 1'b0) begin n_fail++; $display("FAIL noskip_frame k=%0d got %b want 0", k, a_frame); end
         @(negedge clock_50);
      end
      a_en = 1'b0; b_en = 1'b0;
   endtask

   // Three channels, middle one zero-length: ch0 x2, bubble, bubble, ch2 x3.
   task automatic test_zero_slot();
      int exp_g[12] = '{0, 1, 1, 0, 0, 4, 4, 4, 0, 1, 1, 0};
      int exp_c[12] = '{0, 0, 0, 1, 2, 2, 2, 2, 0, 0, 0, 1};
      c_slot_len = {15'd3, 15'd0, 15'd2};
      do_reset();
      for (int k = 0; k < 12; k++) begin
         c_en = 1'b1; c_req = 3'b111;
         #1;
         n_tests++; if (c_grant !== 3'(exp_g[k])) begin n_fail++; $display("FAIL zero_grant k=%0d got %b want %b", k, c_grant, 3'(exp_g[k])); end
         n_tests++; if (c_act !== 2'(exp_c[k])) begin n_fail++; $display("FAIL zero_active k=%0d got %0d want %0d", k, c_act, exp_c[k]); end
         n_tests++; if (c_frame !== (k == 8)) begin n_fail++; $display("FAIL zero_frame k=%0d got %b want %b", k, c_frame, (k == 8)); end
         if (k > 0) begin
            n_tests++; if (c_plot !== (exp_g[k-1] != 0)) begin
               n_fail++; $display("FAIL zero_plot k=%0d got %b want %b", k, c_plot, (exp_g[k-1] != 0)); end
         end
         @(negedge clock_50);
      end
      c_en = 1'b0;
   endtask

   task automatic test_all_zero();
      c_slot_len = '0;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         c_en = 1'b1; c_req = 3'b111;
         #1;
         n_tests++; if (c_grant !== 3'b000) begin n_fail++; $display("FAIL allzero_grant k=%0d got %b want 000", k, c_grant); end
         n_tests++; if (c_frame !== (k > 0 && k % 3 == 0)) begin
            n_fail++; $display("FAIL allzero_frame k=%0d got %b want %b", k, c_frame, (k > 0 && k % 3 == 0)); end
         @(negedge clock_50);
      end
      c_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      a_slot_len = {15'd4, 15'd4};
      do_reset();
      for (int k = 0; k < 7; k++) begin
         a_en = 1'b1; a_req = 2'b11;
         a_x = 16'($urandom) | 16'h0101; a_y = 16'($urandom); a_c = 6'($urandom);
         @(negedge clock_50);
      end
      // Cycle 7: ch1 mid-slot and granted; reset lands on this edge.
      reset = 1'b1;
      #1;
      n_tests++; if (a_grant !== 2'b10) begin n_fail++; $display("FAIL rstmid_pre_grant got %b want 10", a_grant); end
      @(negedge clock_50);
      n_tests++; if ({a_plot, a_vx, a_vy, a_vc, a_act, a_frame, a_grant} !== '0) begin
         n_fail++; $display("FAIL rstmid_state got %h want 0", {a_plot, a_vx, a_vy, a_vc, a_act, a_frame, a_grant}); end
      reset = 1'b0;
      #1;
      n_tests++; if (a_grant !== 2'b00) begin n_fail++; $display("FAIL rstmid_bubble got %b want 00", a_grant); end
      @(negedge clock_50);
      #1;
      n_tests++; if (a_grant !== 2'b01) begin n_fail++; $display("FAIL rstmid_first got %b want 01", a_grant); end
      a_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      a_en = 0; b_en = 0; c_en = 0;
      a_req = 0; b_req = 0; c_req = 0;
      a_slot_len = '0; b_slot_len = '0; c_slot_len = '0;
      a_x = 16'h1234; a_y = 16'h5678; a_c = 6'h2d;
      b_x = 16'h1234; b_y = 16'h5678; b_c = 6'h2d;
      c_x = 24'h123456; c_y = 24'h789abc; c_c = 9'h1ad;
      test_reset();
      test_tdm(4, 2, 0, 1'b0, 30);
      test_tdm($urandom_range(1, 6), $urandom_range(0, 6), 25, 1'b1, 300);
      test_tdm($urandom_range(1, 3), $urandom_range(1, 3), 40, 1'b1, 300);
      test_skip_idle();
      test_zero_slot();
      test_all_zero();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
